dcache: RTL and testbench



---
 rtl/dcache.sv | 145 ++++++++++++++
 tb/tb_dcache.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache for the
// memory stage. Hits are served combinationally in the request cycle. A miss
// stalls the pipeline, evicts the victim line if it is dirty, fills the
// 128-bit line from backing memory, then retries the held request.
//
// Ports
//   clock, reset        : single clock, asynchronous active-high reset
//   m_mem_read/write    : load / store request (both set = store)
//   m_mem_byte          : 1 = byte access, 0 = word access
//   m_addr, m_wdata     : byte address and store data (bytes use [7:0])
//   m_rdata, stall      : load data (valid when stall = 0), pipeline freeze
//   mem_req, mem_we     : backing-memory request, 1 = evict, 0 = fill
//   mem_addr, mem_wdata : line-aligned address and evicted line
//   mem_rdata, mem_ack  : fill line and one-cycle completion pulse
module dcache #(
    parameter int LINES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         m_mem_read,
    input  logic         m_mem_write,
    input  logic         m_mem_byte,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    output logic [31:0]  m_rdata,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVICT,
        S_FILL
    } state_t;

    state_t           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [TW-1:0]    tag_d  [LINES];
    logic [127:0]     data_q [LINES];
    logic [127:0]     data_d [LINES];

    logic [IW-1:0] idx;
    logic [TW-1:0] req_tag;
    logic [127:0]  line;
    logic [31:0]   word_sel;
    logic [7:0]    byte_sel;
    logic          access;
    logic          hit;

    assign idx      = m_addr[4+IW-1:4];
    assign req_tag  = m_addr[31:4+IW];
    assign line     = data_q[idx];
    assign word_sel = line[{m_addr[3:2], 5'b0} +: 32];
    assign byte_sel = line[{m_addr[3:0], 3'b0} +: 8];
    assign access   = m_mem_read | m_mem_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

    // A simultaneous read+write is a store, so it returns no load data.
    assign m_rdata = (m_mem_read & ~m_mem_write)
                   ? (m_mem_byte ? {{24{byte_sel[7]}}, byte_sel} : word_sel)
                   : '0;
    assign stall   = (state_q != S_IDLE) | (access & ~hit);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (hit) begin
                        if (m_mem_write) begin
                            dirty_d[idx] = 1'b1;
                            if (m_mem_byte)
                                data_d[idx][{m_addr[3:0], 3'b0} +: 8] = m_wdata[7:0];
                            else
                                data_d[idx][{m_addr[3:2], 5'b0} +: 32] = m_wdata;
                        end
                    end else if (dirty_q[idx]) begin
                        state_d = S_EVICT;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx], idx, 4'b0};
                mem_wdata = line;
                if (mem_ack) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {m_addr[31:4], 4'b0};
                if (mem_ack) begin
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = req_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and line data are qualified by valid, so they carry no reset.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

    logic         clock = 1'b0;
    logic         reset;
    logic         m_mem_read, m_mem_write, m_mem_byte;
    logic [31:0]  m_addr, m_wdata;
    logic [31:0]  m_rdata;
    logic         stall;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    int errors = 0;
    int checks = 0;

    dcache #(.LINES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .m_mem_read (m_mem_read),
        .m_mem_write(m_mem_write),
        .m_mem_byte (m_mem_byte),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [13];

    localparam logic [127:0] LINE1 = 128'h44443333_22221111_DEADBEEF_00000000;
    localparam logic [127:0] LINE2 = 128'h88887777_66665555_44443333_22221111;
    localparam logic [127:0] LINE3 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] LINE4 = 128'hA5A5A5A5_96969696_0F0F0F0F_76543210;

    int           scyc;
    bit           saw_ev, held_ok;
    logic [31:0]  ev_addr, fl_addr;
    logic [127:0] ev_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic bt,
                         input logic [31:0] addr, input logic [31:0] wdata);
        m_mem_read  = rd;
        m_mem_write = wr;
        m_mem_byte  = bt;
        m_addr      = addr;
        m_wdata     = wdata;
    endtask

    // Entered at negedge+1 of the miss cycle with the request held. Acts as
    // backing memory: acks each transaction k cycles after mem_req rises
    // (k1 for evicts, k2 for fills). Returns at negedge+1 of the first
    // cycle with stall low, or after a bounded number of cycles.
    task automatic miss_run(input int k1, input int k2, input logic [127:0] fill_line);
        int           wcnt;
        logic [31:0]  a0;
        logic [127:0] d0;
        logic         we0;
        wcnt = 0; a0 = '0; d0 = '0; we0 = 1'b0;
        scyc = 0; saw_ev = 1'b0; held_ok = 1'b1;
        ev_addr = '0; ev_data = '0; fl_addr = '0;
        for (int c = 0; c < 60; c++) begin
            if (!stall) break;
            scyc++;
            if (mem_req) begin
                if (wcnt == 0) begin
                    a0 = mem_addr; d0 = mem_wdata; we0 = mem_we;
                    if (mem_we) begin
                        saw_ev  = 1'b1;
                        ev_addr = mem_addr;
                        ev_data = mem_wdata;
                    end else begin
                        fl_addr = mem_addr;
                    end
                end else if (mem_addr !== a0 || mem_wdata !== d0 || mem_we !== we0) begin
                    held_ok = 1'b0;
                end
                if (wcnt == (mem_we ? k1 : k2)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? '0 : fill_line;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clock);
            mem_ack = 1'b0;
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h12345678, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h10B, 32'h0,        32'h00000012, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h107, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h104, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h10E, 32'h0,        32'h44443333, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h10A, 32'h0,        32'h12345678, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h108, 32'h0,        32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h10D, 32'hFFFFFF5A, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h10C, 32'h0,        32'h44445A33, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h109, 32'h0,        32'h00000056, 1'b0};

        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        @(negedge clock); #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Miss to 0x40, enter FILL, then reset mid-cycle
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        chk("miss40_stall", stall, 1'b1);
        chk("miss40_noreq_c0", mem_req, 1'b0);
        @(negedge clock); #1;
        chk("fill40_req", mem_req, 1'b1);
        chk("fill40_addr", mem_addr, 32'h40);
        chk("fill40_we", mem_we, 1'b0);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_stall", stall, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        chk("post_rst_40_miss", stall, 1'b1);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Cold read miss, memory waits 3 cycles
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        #1;
        chk("cold_stall_c0", stall, 1'b1);
        chk("cold_noreq_c0", mem_req, 1'b0);
        miss_run(0, 3, LINE1);
        chk("cold_stall_cycles", scyc, 5);
        chk("cold_no_evict", saw_ev, 1'b0);
        chk("cold_fill_addr", fl_addr, 32'h100);
        chk("cold_held", held_ok, 1'b1);
        chk("cold_rdata", m_rdata, 32'hDEADBEEF);

        // Table-driven hits on the resident line
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].bt, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_rdata", i), m_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
        end

        // Dirty eviction with immediate acks
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        chk("dirty_stall_c0", stall, 1'b1);
        miss_run(0, 0, LINE2);
        chk("dirty_stall_cycles", scyc, 3);
        chk("dirty_saw_evict", saw_ev, 1'b1);
        chk("dirty_evict_addr", ev_addr, 32'h100);
        chk("dirty_evict_word2", ev_data[95:64], 32'h12345678);
        chk("dirty_evict_line", ev_data, 128'h44445A33_12345678_DEADBEEF_CAFEF00D);
        chk("dirty_fill_addr", fl_addr, 32'h140);
        chk("dirty_rdata", m_rdata, 32'h22221111);

        // Byte store merge into the just-filled line
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'h141, 32'h000000AB);
        #1;
        chk("bstore_stall", stall, 1'b0);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        chk("bstore_merge", m_rdata, 32'h2222AB11);

        // Same index, other tag: must evict the merged (dirty) line
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        #1;
        chk("remiss_stall_c0", stall, 1'b1);
        miss_run(1, 2, LINE3);
        chk("remiss_stall_cycles", scyc, 6);
        chk("remiss_evict_addr", ev_addr, 32'h140);
        chk("remiss_evict_line", ev_data, 128'h88887777_66665555_44443333_2222AB11);
        chk("remiss_fill_addr", fl_addr, 32'h100);
        chk("remiss_held", held_ok, 1'b1);
        chk("remiss_rdata", m_rdata, 32'h11111111);

        // Clean miss: fill only
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        miss_run(0, 0, LINE2);
        chk("clean_stall_cycles", scyc, 2);
        chk("clean_no_evict", saw_ev, 1'b0);
        chk("clean_rdata", m_rdata, 32'h22221111);

        // Ack while idle is ignored
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = '1;
        #1;
        chk("idle_ack_req", mem_req, 1'b0);
        chk("idle_ack_stall", stall, 1'b0);
        @(negedge clock);
        mem_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        chk("idle_ack_hit", stall, 1'b0);
        chk("idle_ack_data", m_rdata, 32'h22221111);

        // Reset in the middle of a FILL
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
        #1;
        chk("rfill_stall_c0", stall, 1'b1);
        @(negedge clock); #1;
        chk("rfill_req", mem_req, 1'b1);
        chk("rfill_addr", mem_addr, 32'h180);
        #1;
        reset = 1'b1;
        #1;
        chk("rfill_rst_req", mem_req, 1'b0);
        chk("rfill_rst_addr", mem_addr, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = LINE4;
        #1;
        chk("rfill_late_ack_req", mem_req, 1'b0);
        @(negedge clock);
        mem_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
        #1;
        chk("rfill_remiss", stall, 1'b1);
        chk("rfill_remiss_noreq", mem_req, 1'b0);
        miss_run(0, 0, LINE4);
        chk("rfill_stall_cycles", scyc, 2);
        chk("rfill_no_evict", saw_ev, 1'b0);
        chk("rfill_fill_addr", fl_addr, 32'h180);
        chk("rfill_rdata", m_rdata, 32'h76543210);

        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
